// File: rtl/timer_pkg.sv
// Shared types and constants for the serial-programmed one-shot timer.
package timer_pkg;

    typedef enum logic [2:0] {
        SRCH0,
        SRCH1,
        SRCH11,
        SRCH110,
        SHIFT,
        COUNT,
        WAIT
    } state_t;

    localparam logic [3:0] START_PATTERN = 4'b1101;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running divide-by-PRESCALE counter; tick marks the last cycle of each delay unit.
module timer_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;

    always_comb begin
        pcnt_d = pcnt_q;
        if (clear) begin
            pcnt_d = '0;
        end else if (en) begin
            pcnt_d = (pcnt_q == LAST) ? '0 : pcnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign tick = en && (pcnt_q == LAST);

endmodule

// File: rtl/timer_sequencer.sv
// One-shot timer: detects 1101 on the serial line, shifts in a delay, counts
// (delay+1)*PRESCALE cycles, then holds done until acknowledged.
module timer_sequencer
    import timer_pkg::*;
#(
    parameter int PRESCALE = 1000,
    parameter int DW       = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          data,
    output logic [DW-1:0] count,
    output logic          counting,
    output logic          done,
    input  logic          ack
);

    localparam int BW = $clog2(DW + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] delay_q;
    logic [DW-1:0] delay_d;
    logic [BW-1:0] bitcnt_q;
    logic [BW-1:0] bitcnt_d;
    logic          presc_clear;
    logic          presc_en;
    logic          tick;

    // Prescaler is held at zero throughout SHIFT so COUNT always starts a fresh unit.
    assign presc_clear = (state_q == SHIFT);
    assign presc_en    = (state_q == COUNT);

    timer_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (presc_clear),
        .en     (presc_en),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= SRCH0;
            delay_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            delay_q  <= delay_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    // Search states follow the overlap-aware recogniser for 1101.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SRCH0:   if (data == START_PATTERN[3]) state_d = SRCH1;
            SRCH1:   state_d = (data == START_PATTERN[2]) ? SRCH11 : SRCH0;
            SRCH11:  if (data == START_PATTERN[1]) state_d = SRCH110;
            SRCH110: state_d = (data == START_PATTERN[0]) ? SHIFT : SRCH0;
            SHIFT:   if (bitcnt_q == LAST_BIT) state_d = COUNT;
            COUNT:   if (tick && (delay_q == '0)) state_d = WAIT;
            WAIT:    if (ack) state_d = SRCH0;
            default: state_d = SRCH0;
        endcase
    end

    always_comb begin
        delay_d  = delay_q;
        bitcnt_d = bitcnt_q;
        if (state_q == SRCH110) begin
            bitcnt_d = '0;
        end
        if (state_q == SHIFT) begin
            delay_d  = DW'({delay_q, data});
            bitcnt_d = bitcnt_q + BW'(1);
        end
        if ((state_q == COUNT) && tick && (delay_q != '0)) begin
            delay_d = delay_q - DW'(1);
        end
    end

    always_comb begin
        counting = (state_q == COUNT);
        done     = (state_q == WAIT);
        count    = counting ? delay_q : '0;
    end

endmodule

// File: tb/tb_timer_sequencer.sv
// Scoreboard bench: driver pushes expected runs, a negedge monitor checks them.
module tb_timer_sequencer;

    localparam int P  = 4;
    localparam int DW = 4;

    logic          clk;
    logic          reset_n;
    logic          data;
    logic          ack;
    logic [DW-1:0] count;
    logic          counting;
    logic          done;

    logic          data_b;
    logic          ack_b;
    logic [DW-1:0] count_b;
    logic          counting_b;
    logic          done_b;

    timer_sequencer #(.PRESCALE(P), .DW(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .data    (data),
        .count   (count),
        .counting(counting),
        .done    (done),
        .ack     (ack)
    );

    timer_sequencer #(.PRESCALE(1000), .DW(DW)) dut_big (
        .clk     (clk),
        .reset_n (reset_n),
        .data    (data_b),
        .count   (count_b),
        .counting(counting_b),
        .done    (done_b),
        .ack     (ack_b)
    );

    typedef struct {
        int start;
        int delay;
        int wait_cyc;
    } exp_t;

    exp_t exp_q[$];
    bit   stim[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   idle_err = 0;
    int   overlap_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: first occurrence of 1101 anywhere in the stream marks detection.
    function automatic int find_pat(input bit s[$]);
        for (int i = 3; i < s.size(); i++) begin
            if (s[i-3] && s[i-2] && !s[i-1] && s[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic ack_bit(input int mode);
        if (mode == 2) return 1'b1;
        if (mode == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    task automatic make_stream(input int n, input logic [15:0] v);
        stim.delete();
        for (int i = n - 1; i >= 0; i--) stim.push_back(v[i]);
    endtask

    // Drive one run; ack_mode 0=low,1=random,2=high until expiry; w = cycles of done before ack.
    task automatic run_txn(input bit s[$], input int ack_mode, input int w);
        int   j;
        int   d;
        int   guard;
        exp_t e;
        j = find_pat(s);
        d = 0;
        for (int i = 1; i <= DW; i++) d = d * 2 + int'(s[j+i]);
        @(negedge clk);
        e.start = cyc + 1 + j + DW;
        e.delay = d;
        e.wait_cyc = w;
        exp_q.push_back(e);
        for (int i = 0; i <= j + DW; i++) begin
            if (i > 0) @(negedge clk);
            data = s[i];
            ack  = ack_bit(ack_mode);
        end
        guard = 0;
        while (1) begin
            @(negedge clk);
            if (done) break;
            guard++;
            if (guard > 16 * P + 20) begin
                failures++;
                $display("FAIL done_timeout actual=0 required=1");
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1, "timeout");
            end
            data = 1'($urandom_range(0, 1));
            ack  = ack_bit(ack_mode);
        end
        data = 1'b0;
        ack  = (w == 0);
        for (int k = 1; k <= w; k++) begin
            @(negedge clk);
            ack = (k == w);
        end
        @(negedge clk);
        ack = 1'b0;
    endtask

    // Monitor: pops one expectation per counting window and checks its whole trajectory.
    initial begin
        exp_t cur;
        bit   have = 0;
        bit   prev_cnt = 0;
        bit   prev_done = 0;
        int   k = 0;
        int   seq_err = 0;
        int   done_len = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_q.delete();
                have = 0;
                prev_cnt = 0;
                prev_done = 0;
            end else begin
                if (counting && done) overlap_err++;
                if (!counting && count != '0) idle_err++;
                if (counting && !prev_cnt) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_run", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        have = 1;
                        k = 0;
                        seq_err = 0;
                        chk("start_edge", cyc, cur.start);
                    end
                end
                if (counting && have) begin
                    if (int'(count) != cur.delay - k / P) seq_err++;
                    k++;
                end
                if (!counting && prev_cnt && have) begin
                    chk("count_len", k, (cur.delay + 1) * P);
                    chk("count_seq_errs", seq_err, 0);
                    chk("done_follows", int'(done), 1);
                    done_len = 0;
                end
                if (done) done_len++;
                if (!done && prev_done && have) begin
                    chk("done_len", done_len, cur.wait_cyc + 1);
                    have = 0;
                end
                prev_cnt = counting;
                prev_done = done;
            end
        end
    end

    initial begin
        int len;
        int guard;
        reset_n = 1'b0;
        data = 1'b0;
        ack = 1'b0;
        data_b = 1'b0;
        ack_b = 1'b0;
        #1;
        chk("reset_counting", int'(counting), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_count", int'(count), 0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;

        make_stream(8, 16'b1101_0000);      run_txn(stim, 0, 2);
        make_stream(8, 16'b1101_0101);      run_txn(stim, 0, 1);
        make_stream(9, 16'b1_1101_0011);    run_txn(stim, 0, 0);
        make_stream(12, 16'b1100_1101_0011); run_txn(stim, 0, 3);
        make_stream(8, 16'b1101_0010);      run_txn(stim, 2, 0);

        for (int r = 0; r < 20; r++) begin
            int n;
            n = $urandom_range(0, 8);
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back(1'($urandom_range(0, 1)));
            stim.push_back(1); stim.push_back(1); stim.push_back(0); stim.push_back(1);
            for (int i = 0; i < DW; i++) stim.push_back(1'($urandom_range(0, 1)));
            run_txn(stim, $urandom_range(0, 1), $urandom_range(0, 3));
        end

        // Asynchronous abort mid-COUNT with delay 9.
        make_stream(8, 16'b1101_1001);
        @(negedge clk);
        exp_q.push_back('{start: cyc + 8, delay: 9, wait_cyc: 0});
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            data = stim[i];
        end
        repeat (10) @(negedge clk);
        chk("pre_abort_counting", int'(counting), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_counting", int'(counting), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_count", int'(count), 0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("post_abort_idle", int'(counting), 0);
        make_stream(8, 16'b1101_0001);      run_txn(stim, 0, 1);

        // PRESCALE=1000, delay 15, random data during the run.
        make_stream(8, 16'b1101_1111);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            data_b = stim[i];
        end
        guard = 0;
        do begin
            @(negedge clk);
            data_b = 1'($urandom_range(0, 1));
            guard++;
        end while (!counting_b && guard < 10);
        chk("big_start", int'(counting_b), 1);
        chk("big_count_init", int'(count_b), 15);
        len = 0;
        while (counting_b && len < 17000) begin
            len++;
            @(negedge clk);
            data_b = 1'($urandom_range(0, 1));
        end
        chk("big_len", len, 16000);
        chk("big_done", int'(done_b), 1);
        repeat (3) begin
            @(negedge clk);
            data_b = 1'($urandom_range(0, 1));
        end
        chk("big_done_held", int'(done_b), 1);
        ack_b = 1'b1;
        @(negedge clk);
        ack_b = 1'b0;
        chk("big_done_cleared", int'(done_b), 0);

        repeat (2) @(negedge clk);
        chk("idle_count_zero", idle_err, 0);
        chk("no_overlap", overlap_err, 0);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
